// File: rtl/target_pkg.sv
// Shared definitions for the target sequencer.
//   - state_e       : controller phases, encoded exactly as presented on state_o
//   - ms_to_cycles  : converts a millisecond duration to clock cycles (never below 1)
//   - clamp_coord   : limits a coordinate to the last valid screen pixel
package target_pkg;

    localparam logic [2:0] STATE_IDLE     = 3'd0;
    localparam logic [2:0] STATE_ACQUIRE  = 3'd1;
    localparam logic [2:0] STATE_FIRING   = 3'd2;
    localparam logic [2:0] STATE_COOLDOWN = 3'd3;
    localparam logic [2:0] STATE_COAST    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = STATE_IDLE,
        ST_ACQUIRE  = STATE_ACQUIRE,
        ST_FIRING   = STATE_FIRING,
        ST_COOLDOWN = STATE_COOLDOWN,
        ST_COAST    = STATE_COAST
    } state_e;

    // A zero-length phase would never let the shared timer report expiry,
    // so every duration is at least one cycle.
    function automatic int ms_to_cycles(input int freq_mhz, input int ms);
        int cycles;
        cycles = freq_mhz * 1000 * ms;
        return (cycles < 1) ? 1 : cycles;
    endfunction

    function automatic logic [31:0] clamp_coord(input logic [31:0] v, input logic [31:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating up-counter shared by all timed phases.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   clr_i   : restart the count from zero on the next edge
//   tc_i    : terminal count; the counter holds once it gets there
//   done_o  : count equals the terminal count
module phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic [W-1:0] tc_i,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (count_q < tc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == tc_i);

endmodule

// File: rtl/target_sequencer.sv
// Targeting controller: lock -> fire -> cooldown cycle with a coast period
// that rides out short tracker dropouts.
//   clk, rst               : clock, synchronous active-high reset
//   arm                    : engagement enable; low forces IDLE immediately
//   on_screen              : tracker reports a target
//   tracked_x / tracked_y  : tracker coordinates (clamped to the screen)
//   driven_x / driven_y    : servo command
//   fire                   : laser enable
//   state_o                : current phase encoding
//   shot_count             : completed pulses, saturating
module target_sequencer
    import target_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int LOCK_MS      = 200,
    parameter int FIRE_MS      = 100,
    parameter int COOLDOWN_MS  = 300,
    parameter int GRACE_MS     = 50,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int SHOT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              on_screen,
    input  logic [X_W-1:0]    tracked_x,
    input  logic [Y_W-1:0]    tracked_y,
    output logic [X_W-1:0]    driven_x,
    output logic [Y_W-1:0]    driven_y,
    output logic              fire,
    output logic [2:0]        state_o,
    output logic [SHOT_W-1:0] shot_count
);

    localparam int LOCK_CYCLES     = ms_to_cycles(CLK_FREQ_MHZ, LOCK_MS);
    localparam int FIRE_CYCLES     = ms_to_cycles(CLK_FREQ_MHZ, FIRE_MS);
    localparam int COOLDOWN_CYCLES = ms_to_cycles(CLK_FREQ_MHZ, COOLDOWN_MS);
    localparam int GRACE_CYCLES    = ms_to_cycles(CLK_FREQ_MHZ, GRACE_MS);
    localparam int MAX_A           = (LOCK_CYCLES > FIRE_CYCLES) ? LOCK_CYCLES : FIRE_CYCLES;
    localparam int MAX_B           = (COOLDOWN_CYCLES > GRACE_CYCLES) ? COOLDOWN_CYCLES : GRACE_CYCLES;
    localparam int MAX_CYCLES      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW              = $clog2(MAX_CYCLES + 1);

    localparam logic [X_W-1:0] CENTER_X = X_W'(SCREEN_W / 2);
    localparam logic [Y_W-1:0] CENTER_Y = Y_W'(SCREEN_H / 2);

    state_e            state_q;
    state_e            state_d;
    logic [TW-1:0]     timer_tc;
    logic              timer_done;
    logic              timer_clr;
    logic              shot_inc;
    logic [X_W-1:0]    clamp_x;
    logic [Y_W-1:0]    clamp_y;
    logic [X_W-1:0]    hold_x_q;
    logic [Y_W-1:0]    hold_y_q;
    logic [SHOT_W-1:0] shot_q;

    assign clamp_x = X_W'(clamp_coord(32'(tracked_x), 32'(SCREEN_W - 1)));
    assign clamp_y = Y_W'(clamp_coord(32'(tracked_y), 32'(SCREEN_H - 1)));

    // The timer is cleared on the edge that enters a phase, so a phase of
    // N cycles expires when the count shows N-1.
    always_comb begin
        case (state_q)
            ST_ACQUIRE:  timer_tc = TW'(LOCK_CYCLES - 1);
            ST_FIRING:   timer_tc = TW'(FIRE_CYCLES - 1);
            ST_COOLDOWN: timer_tc = TW'(COOLDOWN_CYCLES - 1);
            ST_COAST:    timer_tc = TW'(GRACE_CYCLES - 1);
            default:     timer_tc = '0;
        endcase
    end

    phase_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (timer_clr),
        .tc_i   (timer_tc),
        .done_o (timer_done)
    );

    // Priority: disarm, then target loss, then timer expiry.
    always_comb begin
        state_d  = state_q;
        shot_inc = 1'b0;
        if (!arm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (on_screen) state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (!on_screen)      state_d = ST_COAST;
                    else if (timer_done) state_d = ST_FIRING;
                end
                ST_FIRING: begin
                    if (!on_screen) begin
                        state_d = ST_COAST;
                    end else if (timer_done) begin
                        state_d  = ST_COOLDOWN;
                        shot_inc = 1'b1;
                    end
                end
                ST_COOLDOWN: begin
                    if (!on_screen)      state_d = ST_COAST;
                    else if (timer_done) state_d = ST_FIRING;
                end
                ST_COAST: begin
                    if (on_screen)       state_d = ST_ACQUIRE;
                    else if (timer_done) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign timer_clr = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hold_x_q <= '0;
            hold_y_q <= '0;
            shot_q   <= '0;
        end else begin
            state_q <= state_d;
            if (on_screen) begin
                hold_x_q <= clamp_x;
                hold_y_q <= clamp_y;
            end
            if (shot_inc && (shot_q != '1)) begin
                shot_q <= shot_q + 1'b1;
            end
        end
    end

    always_comb begin
        driven_x = CENTER_X;
        driven_y = CENTER_Y;
        case (state_q)
            ST_ACQUIRE, ST_FIRING, ST_COOLDOWN: begin
                driven_x = clamp_x;
                driven_y = clamp_y;
            end
            ST_COAST: begin
                driven_x = hold_x_q;
                driven_y = hold_y_q;
            end
            default: ;
        endcase
    end

    assign fire       = (state_q == ST_FIRING);
    assign state_o    = state_q;
    assign shot_count = shot_q;

endmodule

// File: tb/tb_target_sequencer.sv
// Scoreboard bench for target_sequencer. The stimulus side drives one input
// vector per cycle, advances a timestamp-based reference model and queues
// the outputs expected after the next edge; the monitor pops and compares.
module tb_target_sequencer;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int SW = 2;

    localparam int P_IDLE = 0, P_ACQ = 1, P_FIRE = 2, P_COOL = 3, P_COAST = 4;

    logic          clk = 1'b0;
    logic          rst, arm, on_screen;
    logic [XW-1:0] tracked_x, driven_x;
    logic [YW-1:0] tracked_y, driven_y;
    logic          fire;
    logic [2:0]    state_o;
    logic [SW-1:0] shot_count;

    target_sequencer #(
        .CLK_FREQ_MHZ(1), .LOCK_MS(2), .FIRE_MS(1), .COOLDOWN_MS(1), .GRACE_MS(1),
        .X_W(XW), .Y_W(YW), .SCREEN_W(640), .SCREEN_H(480), .SHOT_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .on_screen(on_screen),
        .tracked_x(tracked_x), .tracked_y(tracked_y),
        .driven_x(driven_x), .driven_y(driven_y),
        .fire(fire), .state_o(state_o), .shot_count(shot_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int dx;
        int dy;
        bit fr;
        int shots;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   stim_done = 1'b0;

    // Reference model: phase plus the absolute edge number it was entered on.
    int m_ph = P_IDLE;
    int m_entered = 0;
    int m_edge = 0;
    int m_hx = 0, m_hy = 0;
    int m_shots = 0;

    function automatic int phase_len(input int ph);
        case (ph)
            P_ACQ:   return 2000;
            P_FIRE:  return 1000;
            P_COOL:  return 1000;
            P_COAST: return 1000;
            default: return 0;
        endcase
    endfunction

    function automatic int lim(input int v, input int top);
        return (v > top) ? top : v;
    endfunction

    task automatic model_edge(input bit r, input bit a, input bit o, input int tx, input int ty);
        int  nxt;
        bit  expired;
        exp_t e;
        m_edge++;
        if (r) begin
            m_ph = P_IDLE; m_entered = m_edge; m_hx = 0; m_hy = 0; m_shots = 0;
        end else begin
            expired = (m_ph != P_IDLE) && (m_edge - m_entered >= phase_len(m_ph));
            nxt = m_ph;
            if (!a)                  nxt = P_IDLE;
            else if (m_ph == P_IDLE) nxt = o ? P_ACQ : P_IDLE;
            else if (m_ph == P_COAST) begin
                if (o)            nxt = P_ACQ;
                else if (expired) nxt = P_IDLE;
            end
            else if (!o)             nxt = P_COAST;
            else if (expired) begin
                if (m_ph == P_ACQ)       nxt = P_FIRE;
                else if (m_ph == P_COOL) nxt = P_FIRE;
                else begin
                    nxt = P_COOL;
                    if (m_shots < (1 << SW) - 1) m_shots++;
                end
            end
            if (o) begin
                m_hx = lim(tx, 639);
                m_hy = lim(ty, 479);
            end
            if (nxt != m_ph) begin
                m_ph = nxt;
                m_entered = m_edge;
            end
        end
        e.st = m_ph;
        e.fr = (m_ph == P_FIRE);
        e.shots = m_shots;
        if (m_ph == P_IDLE) begin
            e.dx = 320; e.dy = 240;
        end else if (m_ph == P_COAST) begin
            e.dx = m_hx; e.dy = m_hy;
        end else begin
            e.dx = lim(tx, 639); e.dy = lim(ty, 479);
        end
        q.push_back(e);
    endtask

    task automatic drive_one(input bit r, input bit a, input bit o);
        int tx, ty;
        tx = $urandom_range(0, 1023);
        ty = $urandom_range(0, 511);
        rst = r; arm = a; on_screen = o;
        tracked_x = XW'(tx);
        tracked_y = YW'(ty);
        model_edge(r, a, o, tx, ty);
    endtask

    task automatic run_seg(input int n, input bit r, input bit a, input bit o);
        for (int i = 0; i < n; i++) begin
            drive_one(r, a, o);
            @(negedge clk);
        end
    endtask

    // Monitor
    exp_t got_e;
    int   prev_st = -1;
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            got_e = q.pop_front();
            vectors++;
            if (int'(state_o) != got_e.st || int'(driven_x) != got_e.dx ||
                int'(driven_y) != got_e.dy || fire != got_e.fr ||
                int'(shot_count) != got_e.shots) begin
                miscompares++;
                $display("FAIL outputs @vec %0d: got st=%0d drv=(%0d,%0d) fire=%0b shots=%0d, want st=%0d drv=(%0d,%0d) fire=%0b shots=%0d",
                         vectors, state_o, driven_x, driven_y, fire, shot_count,
                         got_e.st, got_e.dx, got_e.dy, got_e.fr, got_e.shots);
            end
            if (int'(state_o) != prev_st) begin
                $display("vec %0d: state %0d -> %0d drv=(%0d,%0d) fire=%0b shots=%0d",
                         vectors, prev_st, state_o, driven_x, driven_y, fire, shot_count);
                prev_st = int'(state_o);
            end
        end else if (!stim_done) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard: no expected entry, got st=%0d", state_o);
        end
    end

    initial begin
        // Reset and idle with no target.
        run_seg(3, 1, 1, 0);
        run_seg(20, 0, 1, 0);
        // Lock, one full pulse, cooldown, second pulse interrupted by dropout.
        run_seg(4100, 0, 1, 1);
        run_seg(1, 0, 1, 0);
        // Coast briefly, reacquire, drop during lock, return after 400 cycles.
        run_seg(1500, 0, 1, 1);
        run_seg(400, 0, 1, 0);
        run_seg(2100, 0, 1, 1);
        // Dropout during firing held for the full grace period -> IDLE.
        run_seg(1000, 0, 1, 0);
        run_seg(5, 0, 1, 0);
        // Target lost on the very edge the lock timer expires.
        run_seg(2000, 0, 1, 1);
        run_seg(10, 0, 1, 0);
        // Disarm and dropout together mid-pulse.
        run_seg(2500, 0, 1, 1);
        run_seg(1, 0, 0, 0);
        run_seg(5, 0, 1, 0);
        // Continuous target until the 2-bit shot counter saturates, then reset mid-pulse.
        run_seg(12300, 0, 1, 1);
        run_seg(2, 1, 1, 1);
        run_seg(50, 0, 1, 1);
        // Randomized episodes.
        for (int k = 0; k < 15; k++) begin
            bit arm_r;
            arm_r = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) run_seg(2, 1, 1, 1);
            run_seg($urandom_range(1, 2600), 0, arm_r, 1);
            run_seg($urandom_range(1, 1200), 0, 1, 0);
        end
        stim_done = 1'b1;
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard drain: got %0d pending entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
